// File: rtl/fetch_stage_pkg.sv
//==============================================================================
// Module      : fetch_stage_pkg
// Description : Shared constants for the fetch stage: reset PC, opcodes and
//               instruction field positions.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package fetch_stage_pkg;

    localparam logic [31:0] c_reset_pc_default = 32'h0000_0000;

    localparam logic [5:0] c_op_rtype = 6'h00;
    localparam logic [5:0] c_op_j     = 6'h02;
    localparam logic [5:0] c_op_jal   = 6'h03;
    localparam logic [5:0] c_op_beq   = 6'h04;
    localparam logic [5:0] c_op_addi  = 6'h08;
    localparam logic [5:0] c_op_lw    = 6'h23;
    localparam logic [5:0] c_op_sw    = 6'h2B;

    localparam int c_opcode_msb = 31;
    localparam int c_opcode_lsb = 26;
    localparam int c_target_msb = 25;
    localparam int c_target_lsb = 0;
    localparam int c_imm_msb    = 15;
    localparam int c_imm_lsb    = 0;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_stage_if.sv
//==============================================================================
// Module      : fetch_stage_if
// Description : Decode-control, instruction-memory and IF/ID bundle.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface fetch_stage_if;
    logic        stall;
    logic        branch;
    logic        zero;
    logic        jump;
    logic        jr;
    logic [31:0] branch_imm;
    logic [31:0] jr_addr;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] instr_id;
    logic [31:0] pc_plus4_id;
    logic        valid_id;

    modport master (
        input  stall, branch, zero, jump, jr, branch_imm, jr_addr,
        input  imem_rdata, imem_ready,
        output imem_addr, imem_req, instr_id, pc_plus4_id, valid_id
    );

    modport slave (
        output stall, branch, zero, jump, jr, branch_imm, jr_addr,
        output imem_rdata, imem_ready,
        input  imem_addr, imem_req, instr_id, pc_plus4_id, valid_id
    );
endinterface

`default_nettype wire

// File: rtl/fetch_stage_next_pc.sv
//==============================================================================
// Module      : next_pc
// Description : Combinational next-PC select: hold, redirect target, PC+4.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module next_pc
    import fetch_stage_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] pc_plus4_id_i,
    input  logic [25:0] target_i,
    input  logic        valid_id_i,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic        zero_i,
    input  logic        jump_i,
    input  logic        jr_i,
    input  logic        imem_ready_i,
    input  logic [31:0] branch_imm_i,
    input  logic [31:0] jr_addr_i,
    output logic [31:0] pc_plus4_o,
    output logic        redirect_o,
    output logic [31:0] pc_d_o
);
    logic [31:0] w_target;
    logic        w_unused_imm_hi;

    // Word offset shifted to bytes; the top two offset bits fall off.
    assign w_unused_imm_hi = ^branch_imm_i[31:30];

    assign pc_plus4_o = pc_i + 32'd4;
    assign redirect_o = valid_id_i & ~stall_i & (jr_i | jump_i | (branch_i & zero_i));

    always_comb begin
        w_target = pc_plus4_id_i + {branch_imm_i[29:0], 2'b00};
        if (jr_i) begin
            w_target = word_align(jr_addr_i);
        end else if (jump_i) begin
            w_target = {pc_plus4_id_i[31:28], target_i, 2'b00};
        end
    end

    always_comb begin
        pc_d_o = pc_i;
        if (!stall_i) begin
            if (redirect_o) begin
                pc_d_o = w_target;
            end else if (imem_ready_i) begin
                pc_d_o = pc_plus4_o;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_stage.sv
//==============================================================================
// Module      : fetch_stage
// Description : Instruction fetch: PC register, IF/ID pipeline register.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_reset_pc_default
) (
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] instr_id_q;
    logic [31:0] pc_plus4_id_q;
    logic        valid_id_q;
    logic [31:0] w_pc_plus4;
    logic        w_redirect;

    next_pc u_next_pc (
        .pc_i          (pc_q),
        .pc_plus4_id_i (pc_plus4_id_q),
        .target_i      (instr_id_q[c_target_msb:c_target_lsb]),
        .valid_id_i    (valid_id_q),
        .stall_i       (bus.stall),
        .branch_i      (bus.branch),
        .zero_i        (bus.zero),
        .jump_i        (bus.jump),
        .jr_i          (bus.jr),
        .imem_ready_i  (bus.imem_ready),
        .branch_imm_i  (bus.branch_imm),
        .jr_addr_i     (bus.jr_addr),
        .pc_plus4_o    (w_pc_plus4),
        .redirect_o    (w_redirect),
        .pc_d_o        (pc_d)
    );

    // A redirect squashes whatever the wrong-path fetch returned this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            instr_id_q    <= 32'd0;
            pc_plus4_id_q <= 32'd0;
            valid_id_q    <= 1'b0;
        end else begin
            pc_q <= pc_d;
            if (!bus.stall) begin
                if (w_redirect) begin
                    valid_id_q <= 1'b0;
                end else if (bus.imem_ready) begin
                    instr_id_q    <= bus.imem_rdata;
                    pc_plus4_id_q <= w_pc_plus4;
                    valid_id_q    <= 1'b1;
                end else begin
                    valid_id_q <= 1'b0;
                end
            end
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.imem_req    = ~rst & ~bus.stall;
    assign bus.instr_id    = instr_id_q;
    assign bus.pc_plus4_id = pc_plus4_id_q;
    assign bus.valid_id    = valid_id_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
//==============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage (vectors, sequences, random).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fetch_stage;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_stage_if bus();

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference state of the fetch stage as seen from outside.
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;

    typedef struct {
        logic        stall, branch, zero, jump, jr, ready;
        logic [31:0] rdata, imm, jra;
        logic [31:0] e_pc, e_instr, e_pc4;
        logic        e_valid;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic s, b, z, j, r, rdy, input logic [31:0] rd, imm, jra);
        bus.stall = s; bus.branch = b; bus.zero = z; bus.jump = j; bus.jr = r;
        bus.imem_ready = rdy; bus.imem_rdata = rd; bus.branch_imm = imm; bus.jr_addr = jra;
    endtask

    function automatic logic [31:0] model_target();
        if (bus.jr) return bus.jr_addr - (bus.jr_addr % 4);
        if (bus.jump) return (m_pc4 / 32'h1000_0000) * 32'h1000_0000 + (m_instr % 32'h0400_0000) * 4;
        return m_pc4 + bus.branch_imm * 4;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (!bus.stall) begin
            if (m_valid && (bus.jr || bus.jump || (bus.branch && bus.zero))) begin
                m_pc    = model_target();
                m_valid = 1'b0;
            end else if (bus.imem_ready) begin
                m_instr = bus.imem_rdata;
                m_pc4   = m_pc + 4;
                m_pc    = m_pc + 4;
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic compare_model(input string tag);
        check({tag, ".imem_addr"},   bus.imem_addr,   m_pc);
        check({tag, ".valid_id"},    bus.valid_id,    m_valid);
        check({tag, ".imem_req"},    bus.imem_req,    !bus.stall);
        if (m_valid) begin
            check({tag, ".instr_id"},    bus.instr_id,    m_instr);
            check({tag, ".pc_plus4_id"}, bus.pc_plus4_id, m_pc4);
        end
    endtask

    // Asynchronous reset asserted away from any clock edge.
    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        check("rst.imem_addr",   bus.imem_addr,   32'h0);
        check("rst.instr_id",    bus.instr_id,    32'h0);
        check("rst.pc_plus4_id", bus.pc_plus4_id, 32'h0);
        check("rst.valid_id",    bus.valid_id,    1'b0);
        check("rst.imem_req",    bus.imem_req,    1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic jr_to(input logic [31:0] addr);
        drive(0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0);
        tick();
        drive(0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF, 32'h0, addr);
        tick();
        check("jr_to.imem_addr", bus.imem_addr, addr & 32'hFFFF_FFFC);
        drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        //          st b  z  j  jr rdy rdata          imm           jra    e_pc   e_instr        e_pc4  e_valid
        tbl[0] = '{0, 0, 0, 0, 0, 1, 32'h2001_0001, 32'h0,        32'h0, 32'h4, 32'h2001_0001, 32'h4,  1};
        tbl[1] = '{0, 0, 0, 0, 0, 1, 32'h0022_1820, 32'h0,        32'h0, 32'h8, 32'h0022_1820, 32'h8,  1};
        tbl[2] = '{0, 0, 0, 0, 0, 1, 32'hAC03_0000, 32'h0,        32'h0, 32'hC, 32'hAC03_0000, 32'hC,  1};
        tbl[3] = '{0, 0, 0, 0, 0, 1, 32'h1022_FFFE, 32'h0,        32'h0, 32'h10,32'h1022_FFFE, 32'h10, 1};
        tbl[4] = '{0, 1, 1, 0, 0, 1, 32'hBAD0_0000, 32'hFFFF_FFFE,32'h0, 32'h8, 32'h1022_FFFE, 32'h10, 0};
        tbl[5] = '{0, 1, 1, 0, 0, 1, 32'h8C01_0008, 32'hFFFF_FFFE,32'h0, 32'hC, 32'h8C01_0008, 32'hC,  1};
        tbl[6] = '{0, 1, 0, 0, 0, 0, 32'hBAD0_0001, 32'h0,        32'h0, 32'hC, 32'h8C01_0008, 32'hC,  0};
        tbl[7] = '{1, 0, 0, 1, 0, 1, 32'hBAD0_0002, 32'h0,        32'h0, 32'hC, 32'h8C01_0008, 32'hC,  0};

        drive(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
        do_reset();

        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].stall, tbl[i].branch, tbl[i].zero, tbl[i].jump, tbl[i].jr,
                  tbl[i].ready, tbl[i].rdata, tbl[i].imm, tbl[i].jra);
            tick();
            check($sformatf("vec%0d.imem_addr", i),   bus.imem_addr,   tbl[i].e_pc);
            check($sformatf("vec%0d.instr_id", i),    bus.instr_id,    tbl[i].e_instr);
            check($sformatf("vec%0d.pc_plus4_id", i), bus.pc_plus4_id, tbl[i].e_pc4);
            check($sformatf("vec%0d.valid_id", i),    bus.valid_id,    tbl[i].e_valid);
            check($sformatf("vec%0d.imem_req", i),    bus.imem_req,    !tbl[i].stall);
        end

        // JAL then jr
        jr_to(32'h1000_0000);
        drive(0, 0, 0, 0, 0, 1, 32'h0C00_0040, 32'h0, 32'h0);
        tick();
        check("jal.fetch_pc4", bus.pc_plus4_id, 32'h1000_0004);
        check("jal.fetch_valid", bus.valid_id, 1'b1);
        drive(0, 0, 0, 1, 0, 1, 32'hBAD0_0003, 32'h0, 32'h0);
        tick();
        check("jal.target", bus.imem_addr, 32'h1000_0100);
        check("jal.bubble", bus.valid_id, 1'b0);
        drive(0, 0, 0, 0, 0, 1, 32'h0, 32'h0, 32'h0);
        tick();
        drive(0, 0, 0, 0, 1, 1, 32'hBAD0_0004, 32'h0, 32'h0000_0203);
        tick();
        check("jr.target", bus.imem_addr, 32'h0000_0200);

        // Stall holding a taken branch for three cycles
        drive(0, 0, 0, 0, 0, 1, 32'h1022_FFFE, 32'h0, 32'h0);
        tick();
        drive(1, 1, 1, 0, 0, 1, 32'hBAD0_0005, 32'hFFFF_FFFE, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("stall%0d.imem_addr", k), bus.imem_addr, 32'h0000_0204);
            check($sformatf("stall%0d.instr_id", k),  bus.instr_id,  32'h1022_FFFE);
            check($sformatf("stall%0d.valid_id", k),  bus.valid_id,  1'b1);
            check($sformatf("stall%0d.imem_req", k),  bus.imem_req,  1'b0);
        end
        bus.stall = 1'b0;
        tick();
        check("stall.release_target", bus.imem_addr, 32'h0000_01FC);
        check("stall.release_bubble", bus.valid_id, 1'b0);

        // Memory wait at 0x20, then reset mid-wait
        jr_to(32'h0000_0020);
        for (int k = 0; k < 2; k++) begin
            tick();
            check($sformatf("wait%0d.imem_addr", k), bus.imem_addr, 32'h0000_0020);
            check($sformatf("wait%0d.valid_id", k),  bus.valid_id,  1'b0);
        end
        do_reset();
        drive(0, 0, 0, 0, 0, 1, 32'h2001_0007, 32'h0, 32'h0);
        tick();
        check("post_rst.imem_addr", bus.imem_addr, 32'h0000_0004);
        check("post_rst.valid_id",  bus.valid_id,  1'b1);
        check("post_rst.instr_id",  bus.instr_id,  32'h2001_0007);

        // PC wrap
        jr_to(32'hFFFF_FFFC);
        drive(0, 0, 0, 0, 0, 1, 32'h0000_0011, 32'h0, 32'h0);
        tick();
        check("wrap.imem_addr",   bus.imem_addr,   32'h0000_0000);
        check("wrap.pc_plus4_id", bus.pc_plus4_id, 32'h0000_0000);
        check("wrap.valid_id",    bus.valid_id,    1'b1);

        // Randomized traffic against the reference model
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] r;
            r = $urandom;
            if (c % 500 == 499) do_reset();
            drive(($urandom % 5) == 0, ($urandom % 3) == 0, ($urandom % 2) == 0,
                  ($urandom % 6) == 0, ($urandom % 8) == 0, ($urandom % 4) != 0,
                  $urandom, {{16{r[15]}}, r[15:0]}, $urandom);
            tick();
            compare_model($sformatf("rnd%0d", c));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset; bits [1:0] SHALL be zero.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 stall  input  1  decode-stage hazard hold; freezes PC and IF/ID register.
REQ-005 branch  input  1  decode-stage branch control for the instruction in IF/ID.
REQ-006 zero  input  1  comparator result for the branch in decode.
REQ-007 jump  input  1  decode-stage J/JAL control.
REQ-008 jr  input  1  decode-stage jump-register control.
REQ-009 branch_imm  input  32  sign-extended 16-bit branch offset, in words.
REQ-010 jr_addr  input  32  register-file value for jr.
REQ-011 imem_addr  output  32  instruction fetch address, equals current PC.
REQ-012 imem_req  output  1  fetch request.
REQ-013 imem_rdata  input  32  instruction word, valid when imem_ready=1.
REQ-014 imem_ready  input  1  memory returns imem_rdata this cycle.
REQ-015 instr_id  output  32  IF/ID instruction; instr_id[31:26] feeds the main decoder opcode.
REQ-016 pc_plus4_id  output  32  IF/ID PC+4 (JAL link value, branch base).
REQ-017 valid_id  output  1  IF/ID holds a real instruction; 0 means bubble.

Function
REQ-018 imem_addr SHALL equal PC combinationally; imem_req SHALL be 1 whenever rst=0 and stall=0.
REQ-019 redirect = valid_id & ~stall & (jr | jump | (branch & zero)); decode controls SHALL be ignored when valid_id=0 or stall=1.
REQ-020 Target priority: jr -> {jr_addr[31:2],2'b00}; else jump -> {pc_plus4_id[31:28], instr_id[25:0], 2'b00}; else branch -> pc_plus4_id + (branch_imm << 2), mod 2^32.
REQ-021 Priority per edge: rst > stall > redirect > normal fetch > memory wait.
REQ-022 stall=1: PC, instr_id, pc_plus4_id, valid_id SHALL hold.
REQ-023 redirect: PC <= target; valid_id <= 0 (wrong-path fetch discarded, regardless of imem_ready); instr_id/pc_plus4_id may hold.
REQ-024 normal fetch (imem_ready=1): instr_id <= imem_rdata; pc_plus4_id <= PC+4; valid_id <= 1; PC <= PC+4.
REQ-025 memory wait (imem_ready=0): PC holds; valid_id <= 0; imem_addr stays stable until accepted.
REQ-026 PC+4 SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000 without error.
REQ-027 Latency: instruction returned at PC in cycle N appears on instr_id with valid_id=1 in cycle N+1; taken redirect costs exactly one bubble.

Reset
REQ-028 Asserting rst SHALL immediately set PC=RESET_PC, instr_id=0, pc_plus4_id=0, valid_id=0, independent of clk.
REQ-029 Reset mid-wait or mid-redirect SHALL abandon the pending fetch; first request after deassertion is to RESET_PC.
REQ-030 First rising edge after deassertion SHALL behave as a normal cycle (no extra bubble).

Structure
REQ-031 Shared package SHALL hold RESET_PC default, opcode constants (R-type, ADDI, BEQ, J, JAL, SW, LW) and instruction field bit positions.
REQ-032 Next-PC selection SHALL be a combinational sub-module next_pc; PC and IF/ID registers stay in fetch_stage.

Verification
REQ-033 Reset then imem_ready=1 constant with sequential words -> imem_addr 0,4,8,...; instr_id follows one cycle later with valid_id=1.
REQ-034 BEQ in ID at pc_plus4_id=0x10, branch=1, zero=1, branch_imm=-2 -> next PC=0x08, valid_id=0 for one cycle.
REQ-035 JAL with instr_id[25:0]=0x0000040, pc_plus4_id=0x1000_0004 -> PC=0x1000_0100; jr with jr_addr=0x0000_0203 -> PC=0x0000_0200.
REQ-036 stall=1 with branch=1, zero=1 for 3 cycles -> PC, instr_id, valid_id unchanged; redirect taken on first cycle stall=0.
REQ-037 imem_ready=0 for 2 cycles at PC=0x20 -> imem_addr held 0x20, valid_id=0; rst pulse mid-wait -> PC=RESET_PC asynchronously.
REQ-038 PC=0xFFFF_FFFC with imem_ready=1 -> next PC=0x0000_0000, pc_plus4_id=0x0000_0000.
